add_scheduler: RTL and testbench
================================

# add_scheduler

Shares one external 16-bit combinational adder (`Add`-style: `a`, `b` in, `sum` out, no carry port) between up to NREQ requesting units of the calculator, e.g. the keypad accumulator, the multiply sequencer and the function evaluator. It uses round-robin arbitration over a valid/ready handshake and registers the operands that drive the adder. It returns each result on a single response channel, tagged with the requester ID and carry/overflow flags derived locally.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, operand/result width; must match the attached adder

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request strobe
- req_a  in  NREQ*W  packed operand A; requester i at [i*W +: W]
- req_b  in  NREQ*W  packed operand B, same packing
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- add_a  out  W  registered operand A to adder
- add_b  out  W  registered operand B to adder
- add_sum  in  W  adder result (combinational from add_a/add_b)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  $clog2(NREQ)  index of requester that owns the response
- rsp_sum  out  W  captured sum
- rsp_carry  out  1  unsigned carry-out: (rsp_sum < operand A), unsigned compare
- rsp_ovf  out  1  signed overflow: A[W-1]==B[W-1] and sum[W-1]!=A[W-1]

## Operation
- FSM states: IDLE, CALC, RESP. One operation outstanding at a time.
- IDLE: if any req_valid, grant the first asserted requester searching upward (with wrap) from last_grant+1. req_ready is combinational, one-hot, and asserted only in IDLE for the winner. On the transfer, load the operand registers (driving add_a/add_b) with the winner's A/B, store the ID, set last_grant to the winner, and go to CALC. With no request, stay in IDLE with req_ready=0.
- CALC: sample add_sum into rsp_sum, and compute rsp_carry and rsp_ovf from the operand registers and add_sum. Set rsp_valid and go to RESP.
- RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0. When rsp_valid & rsp_ready, clear rsp_valid and go to IDLE. No arbitration occurs in that same cycle.
- Arithmetic is modulo 2^W. Carry and overflow are flags only; the sum is never saturated.
- A requester must hold req_valid and its operands until granted. Deasserting before the grant is legal; that requester is simply skipped.
- Requests arriving during CALC/RESP wait. The grant is decided from req_valid in the IDLE cycle only.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,2,…,NREQ-1,0,…

## Timing
- Reset (rst=1 at a clock edge):
  - state=IDLE, req_ready=0 during reset, add_a=add_b=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rsp_ovf=0.
  - last_grant=NREQ-1, so requester 0 has first priority after reset.
- Reset mid-operation (CALC or RESP) discards the pending result. No response is emitted for it.
- Latency: grant in cycle N, add_a/add_b valid in N+1, rsp_valid high from N+2.
- Minimum issue interval is 3 cycles, with rsp_ready held high: grant in N, rsp_valid in N+2, response taken in N+2, IDLE in N+3, next grant in N+3.
- add_a/add_b stay stable from N+1 until the next grant. The adder path must close in one cycle.
- rsp_ready is ignored while rsp_valid=0.

## Test plan
- Reset then single request: req_valid=0001, A=0x1234, B=0x0FF0. Required: req_ready=0001 in the same cycle, and two cycles later rsp_valid=1, rsp_id=0, rsp_sum=0x2224, carry=0, ovf=0.
- Flags:
  - A=0xFFFF, B=0x0001 -> rsp_sum=0x0000, carry=1, ovf=0.
  - A=0x7FFF, B=0x0001 -> rsp_sum=0x8000, carry=0, ovf=1.
  - A=0x8000, B=0x8000 -> rsp_sum=0x0000, carry=1, ovf=1.
- Round-robin: all four request continuously with distinct operands and rsp_ready=1. Required: rsp_id sequence 0,1,2,3,0,1, each sum correct, and grants exactly 3 cycles apart.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid rises. Required: rsp_* stay constant, req_ready stays 0000 despite pending requests, and the next grant comes the cycle after the rsp_ready handshake.
- Skip/withdraw: last_grant=1, req_valid=1101 with requester 2 dropping its request before IDLE. Required: the next grant goes to requester 3, then requester 0.
- Reset mid-op: assert rst during RESP with rsp_valid=1. Required: rsp_valid=0 in the next cycle, no stale response, and a subsequent request 0001 is granted normally.

Source files
------------

// File: rtl/add_scheduler.sv
// Round-robin front end that shares one external combinational adder between
// NREQ requesters, returning tagged results with carry/overflow flags.
module add_scheduler #(
   parameter int NREQ = 4,
   parameter int W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*W-1:0]        req_a,
   input  logic [NREQ*W-1:0]        req_b,
   output logic [NREQ-1:0]          req_ready,
   output logic [W-1:0]             add_a,
   output logic [W-1:0]             add_b,
   input  logic [W-1:0]             add_sum,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [W-1:0]             rsp_sum,
   output logic                     rsp_carry,
   output logic                     rsp_ovf
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   last_q, last_d, id_q, id_d, win;
   logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic            vld_q, vld_d, carry_q, carry_d, ovf_q, ovf_d;
   logic            any;
   logic [NREQ-1:0] grant;

   // Scan downward from the farthest slot so the nearest one after
   // last_q overwrites and wins.
   always_comb begin
      int idx;
      win = '0;
      any = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last_q) + k) % NREQ;
         if (req_valid[idx]) begin
            win = IW'(idx);
            any = 1'b1;
         end
      end
      grant = any ? (NREQ'(1) << win) : '0;
   end

   assign req_ready = (state_q == IDLE && !rst) ? grant : '0;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      vld_d   = vld_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (any) begin
               a_d     = req_a[int'(win)*W +: W];
               b_d     = req_b[int'(win)*W +: W];
               id_d    = win;
               last_d  = win;
               state_d = CALC;
            end
         end
         CALC: begin
            sum_d   = add_sum;
            carry_d = (add_sum < a_q);
            ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[W-1] != a_q[W-1]);
            vld_d   = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= IW'(NREQ - 1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         vld_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         vld_q   <= vld_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign add_a     = a_q;
   assign add_b     = b_q;
   assign rsp_valid = vld_q;
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_carry = carry_q;
   assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_add_scheduler.sv
// Directed and randomized checks of add_scheduler against an arithmetic
// reference model with an ideal adder attached.
module tb_add_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req_valid, req_ready;
   logic [63:0]     req_a, req_b;
   logic [15:0]     add_a, add_b, add_sum, rsp_sum;
   logic            rsp_valid, rsp_ready, rsp_carry, rsp_ovf;
   logic [1:0]      rsp_id;
   logic [15:0]     opa [4];
   logic [15:0]     opb [4];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int last_gcyc = 0;
   int m_last;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = opa[i];
         req_b[i*16 +: 16] = opb[i];
      end
   end

   assign add_sum = add_a + add_b;

   add_scheduler #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // First requester found walking upward (with wrap) past the last winner.
   function automatic int pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++)
         if (v[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   task automatic randomize_ops();
      for (int i = 0; i < 4; i++) begin
         opa[i] = 16'($urandom);
         opb[i] = 16'($urandom);
      end
   endtask

   // One transaction starting in an IDLE cycle: grant, operand capture,
   // response with `stall` cycles of back-pressure, then handshake.
   task automatic txn(input logic [3:0] vld, input logic [3:0] vld_busy,
                      input int stall, input bit chk_gap);
      int          w, ss;
      logic [3:0]  oh;
      logic [15:0] ea, eb;
      logic [16:0] us;
      logic        eo;
      req_valid = vld;
      rsp_ready = 1'b0;
      w  = pick(vld, m_last);
      oh = 4'b0001 << w;
      #3;
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("grant", req_ready, oh);
      if (chk_gap) chk("grant_gap", cyc - last_gcyc, 3);
      last_gcyc = cyc;
      ea = opa[w];
      eb = opb[w];
      m_last = w;
      us = {1'b0, ea} + {1'b0, eb};
      ss = int'($signed(ea)) + int'($signed(eb));
      eo = (ss > 32767) || (ss < -32768);
      step();
      // the granted requester moves on to new operands immediately
      req_valid = vld_busy;
      opa[w] = 16'($urandom);
      opb[w] = 16'($urandom);
      #3;
      chk("add_a", add_a, ea);
      chk("add_b", add_b, eb);
      chk("calc_rsp_valid", rsp_valid, 0);
      chk("calc_ready", req_ready, 0);
      rsp_ready = (stall == 0);
      step();
      #3;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, w);
      chk("rsp_sum", rsp_sum, us[15:0]);
      chk("rsp_carry", rsp_carry, us[16]);
      chk("rsp_ovf", rsp_ovf, eo);
      chk("resp_ready", req_ready, 0);
      for (int s = 1; s <= stall; s++) begin
         step();
         if (s == stall) rsp_ready = 1'b1;
         #3;
         chk("hold_valid", rsp_valid, 1);
         chk("hold_id", rsp_id, w);
         chk("hold_sum", rsp_sum, us[15:0]);
         chk("hold_flags", {rsp_carry, rsp_ovf}, {us[16], eo});
         chk("hold_ready", req_ready, 0);
      end
      step();
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin opa[i] = '0; opb[i] = '0; end
      step();
      step();
      req_valid = 4'hF;
      #3;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_carry, rsp_ovf}, 0);
      chk("rst_sum", rsp_sum, 0);
      chk("rst_add", {add_a, add_b}, 0);
      step();
      rst = 1'b0;
      req_valid = '0;
      m_last = 3;
      #3;
      chk("idle_no_req", req_ready, 0);
      step();

      // single request and flag corners
      opa[0] = 16'h1234; opb[0] = 16'h0FF0; txn(4'b0001, 4'b0000, 0, 0);
      opa[0] = 16'hFFFF; opb[0] = 16'h0001; txn(4'b0001, 4'b0000, 0, 0);
      opa[0] = 16'h7FFF; opb[0] = 16'h0001; txn(4'b0001, 4'b0000, 0, 0);
      opa[0] = 16'h8000; opb[0] = 16'h8000; txn(4'b0001, 4'b0000, 0, 0);

      // round robin from a fresh reset, all requesting continuously
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_last = 3;
      randomize_ops();
      for (int i = 0; i < 6; i++) txn(4'b1111, 4'b1111, 0, i > 0);

      // back-pressure with requests pending
      randomize_ops();
      txn(4'b0001, 4'b1111, 5, 0);

      // skip a withdrawn requester
      txn(4'b0010, 4'b1110, 0, 0);
      txn(4'b1101, 4'b1101, 0, 0);
      txn(4'b1101, 4'b0000, 0, 0);

      // reset while a response is pending
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      #3;
      chk("mid_grant", req_ready, 4'b0001);
      step();
      req_valid = '0;
      step();
      #3;
      chk("mid_rsp_valid", rsp_valid, 1);
      rst = 1'b1;
      rsp_ready = 1'b1;
      step();
      #3;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_sum", {rsp_sum, 2'(rsp_id)}, 0);
      chk("mid_rst_add", {add_a, add_b}, 0);
      step();
      rst = 1'b0;
      m_last = 3;
      txn(4'b0001, 4'b0000, 0, 0);

      // randomized traffic
      for (int i = 0; i < 24; i++) begin
         logic [3:0] v;
         randomize_ops();
         v = 4'($urandom_range(1, 15));
         txn(v, 4'($urandom), int'($urandom_range(0, 2)), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
